genesis_pad_poller: RTL and testbench
=====================================

Name: genesis_pad_poller

Overview:
Frame-synchronous scan controller for two Genesis controller ports. Each poll is triggered by a vertical-blank edge. For each port in turn, the block drives the standard 8-phase TH (select) sequence, samples the 6-bit pad lines after a settle delay, and classifies the pad as Master System, 3-button or 6-button. It decodes the pad into a 12-bit button word. Sits between the board pad connectors and the core's joystick inputs.

Parameters:
PHASE_TICKS, 500, clocks per select phase (10 us at 50 MHz); must be greater than SETTLE_TICKS.
SETTLE_TICKS, 32, clocks after phase start before the pad lines are sampled.
COOLDOWN_TICKS, 75000, clocks with select held high after a poll (1.5 ms, 6-button counter reset).
AUTOPOLL_TICKS, 1000000, autopoll period; used only with the optional feature.

Ports:
iCLK  in  1  system clock, 50 MHz
iRESET  in  1  asynchronous, active-high reset
iVBLANK  in  1  vertical blank level; a rising edge requests a poll
iPAD1  in  6  port 1 lines {C/Start, B/A, Up/Z, Down/Y, Left/X, Right/Mode}, active low
iPAD2  in  6  port 2 lines, same format as iPAD1
oSELECT1  out  1  port 1 TH line
oSELECT2  out  1  port 2 TH line
oPAD1_DECODED  out  12  {Z,Y,X,M,S,C,B,A,U,D,L,R}, active high
oPAD2_DECODED  out  12  same format as oPAD1_DECODED
oPAD1_TYPE  out  2  0 MS/unknown, 1 3-button, 2 6-button, 3 identify error
oPAD2_TYPE  out  2  same encoding as oPAD1_TYPE
oBUSY  out  1  high in PHASE and COOLDOWN states
oPOLL_DONE  out  1  one-cycle pulse when a poll completes

Behaviour:
- Reset values (async, immediate): oSELECT1 = oSELECT2 = 1; both DECODED = 0; both TYPE = 0; oBUSY = 0; oPOLL_DONE = 0; state = IDLE; pending = 0; vblank_prev = 1, so there is no spurious trigger at reset release.
- Trigger: iVBLANK = 1 and vblank_prev = 0 at clock edge N.
- States:
  - IDLE: on trigger, go to PHASE at N+1 with port = 1, phase = 0, tick = 0.
  - PHASE: tick counts 0..PHASE_TICKS-1, then phase increments. After phase 7 of port 1, go to port 2 phase 0. After phase 7 of port 2, go to COOLDOWN and pulse oPOLL_DONE in that same cycle.
  - COOLDOWN: lasts COOLDOWN_TICKS cycles, then goes to IDLE. If pending = 1, it instead clears pending and goes directly to PHASE with port 1, phase 0.
- Select drive: the active port's select = 1 in even phases and 0 in odd phases. The inactive port and all non-PHASE states hold select = 1.
- Sample: taken on the cycle where tick == SETTLE_TICKS, into per-port shadow registers:
  - ph0: C,B,U,D,L,R = ~iPAD[5:0]
  - ph1: S,A = ~iPAD[5:4]; has3 = (iPAD[1:0] == 00)
  - ph5: has6 = (iPAD[3:0] == 0000)
  - ph6: Z,Y,X,M = ~iPAD[3:0]
  - ph7: ok6 = (iPAD[3:0] == 1111)
- Commit: on the last cycle of the port's phase 7, DECODED and TYPE are updated together, never partially.
  - has3 = 0: TYPE = 0; S, A, Z, Y, X, M forced to 0; C, B, U, D, L, R from ph0.
  - has3 = 1, has6 = 0: TYPE = 1; Z, Y, X, M forced to 0.
  - has3 = 1, has6 = 1, ok6 = 1: TYPE = 2; all 12 bits valid.
  - has3 = 1, has6 = 1, ok6 = 0: TYPE = 3; Z, Y, X, M forced to 0; the rest valid.
- Trigger while oBUSY = 1: sets pending. Further triggers while pending = 1 are dropped; at most one is queued.
- Trigger on the same cycle COOLDOWN ends: treated as pending, so the next poll starts immediately.
- Full poll latency from trigger to oPOLL_DONE: 1 + 16*PHASE_TICKS cycles.
- Reset asserted mid-poll aborts the poll. Previously committed outputs are cleared to their reset values.

Optional Feature:
GENPAD_AUTOPOLL_EN: when defined, a free-running counter generates an internal trigger every AUTOPOLL_TICKS cycles. This trigger is ORed with the iVBLANK edge and follows the same pending rules. The counter restarts at 0 whenever any trigger is accepted from IDLE. When undefined, only iVBLANK triggers polls and AUTOPOLL_TICKS is unused.

Test Plan:
1. 3-button model on port 1 with A and Up held; port 2 lines all 1s; one vblank edge -> oPAD1_TYPE = 1, oPAD1_DECODED = 12'h018; oPAD2_TYPE = 0, oPAD2_DECODED = 12'h000; oPOLL_DONE pulses exactly 8001 cycles after the trigger edge (defaults).
2. 6-button model on port 2 with X and Mode held (ph5 returns 0000, ph6 returns 1100, ph7 returns 1111) -> oPAD2_TYPE = 2, oPAD2_DECODED = 12'h300.
3. Port 1 model returns 0000 at ph5 but 0101 at ph7 -> oPAD1_TYPE = 3, oPAD1_DECODED[11:8] = 0.
4. Edges at t0, t0+2000 and t0+4000 -> second poll starts on the first cycle after COOLDOWN; the third edge is dropped; exactly 2 oPOLL_DONE pulses.
5. iRESET pulsed during port 2 phase 3 -> same cycle: oSELECT2 = 1, both DECODED = 0, oBUSY = 0; no oPOLL_DONE; a new vblank edge then gives a normal poll.
6. Select timing check: oSELECT1 falls at trigger + 1 + 500 cycles; 4 low pulses of 500 cycles each; oSELECT2 stays high throughout the port 1 half of the poll.

Source files
------------

// File: rtl/genesis_pad_poller.sv
// Frame-synchronous scanner for two Genesis pad ports: 8-phase TH sequence per port, pad classification, 12-bit decode.
// Optional feature macro: GENPAD_AUTOPOLL_EN (free-running autopoll trigger ORed with the vblank edge).
module genesis_pad_poller #(
  parameter int PHASE_TICKS    = 500,
  parameter int SETTLE_TICKS   = 32,
  parameter int COOLDOWN_TICKS = 75000,
  parameter int AUTOPOLL_TICKS = 1000000
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic        iVBLANK,
  input  logic [5:0]  iPAD1,
  input  logic [5:0]  iPAD2,
  output logic        oSELECT1,
  output logic        oSELECT2,
  output logic [11:0] oPAD1_DECODED,
  output logic [11:0] oPAD2_DECODED,
  output logic [1:0]  oPAD1_TYPE,
  output logic [1:0]  oPAD2_TYPE,
  output logic        oBUSY,
  output logic        oPOLL_DONE
);

  localparam int TICK_W = $clog2(PHASE_TICKS + 1);
  localparam int COOL_W = $clog2(COOLDOWN_TICKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PHASE    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                port_reg, port_next;
  logic [2:0]          phase_reg, phase_next;
  logic [TICK_W-1:0]   tick_reg, tick_next;
  logic [COOL_W-1:0]   cool_reg, cool_next;
  logic                pending_reg, pending_next;
  logic                done_reg, done_next;
  logic                vblank_prev_reg;
  logic                trig_reg;
  logic                trig_src;
  logic                phase_end;
  logic                last_phase;
  logic                cool_end;

  if (PHASE_TICKS <= SETTLE_TICKS || COOLDOWN_TICKS < 1 || AUTOPOLL_TICKS < 1) begin : g_cfg_check
    $error("genesis_pad_poller: PHASE_TICKS must exceed SETTLE_TICKS; tick counts must be positive");
  end

  assign phase_end  = (tick_reg == TICK_W'(PHASE_TICKS - 1));
  assign last_phase = phase_end && (phase_reg == 3'd7);
  assign cool_end   = (cool_reg == COOL_W'(COOLDOWN_TICKS - 1));

`ifdef GENPAD_AUTOPOLL_EN
  localparam int AP_W = $clog2(AUTOPOLL_TICKS + 1);
  logic [AP_W-1:0] ap_reg;
  logic            ap_hit;

  assign ap_hit   = (ap_reg == AP_W'(AUTOPOLL_TICKS - 1));
  assign trig_src = (iVBLANK & ~vblank_prev_reg) | ap_hit;

  // Restarting on an accepted IDLE trigger keeps autopolls a full period away from vblank polls.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      ap_reg <= '0;
    end else if (ap_hit || (state_reg == ST_IDLE && trig_reg)) begin
      ap_reg <= '0;
    end else begin
      ap_reg <= ap_reg + AP_W'(1);
    end
  end
`else
  assign trig_src = iVBLANK & ~vblank_prev_reg;
`endif

  // The trigger is registered once, so a poll starts one cycle after the detecting edge.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_reg       <= ST_IDLE;
      port_reg        <= 1'b0;
      phase_reg       <= 3'd0;
      tick_reg        <= '0;
      cool_reg        <= '0;
      pending_reg     <= 1'b0;
      done_reg        <= 1'b0;
      vblank_prev_reg <= 1'b1;
      trig_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      port_reg        <= port_next;
      phase_reg       <= phase_next;
      tick_reg        <= tick_next;
      cool_reg        <= cool_next;
      pending_reg     <= pending_next;
      done_reg        <= done_next;
      vblank_prev_reg <= iVBLANK;
      trig_reg        <= trig_src;
    end
  end

  always_comb begin
    state_next   = state_reg;
    port_next    = port_reg;
    phase_next   = phase_reg;
    tick_next    = tick_reg;
    cool_next    = cool_reg;
    pending_next = pending_reg;
    done_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (trig_reg) begin
          state_next = ST_PHASE;
          port_next  = 1'b0;
          phase_next = 3'd0;
          tick_next  = '0;
        end
      end

      ST_PHASE: begin
        if (trig_reg) begin
          pending_next = 1'b1;
        end
        if (phase_end) begin
          tick_next = '0;
          if (phase_reg == 3'd7) begin
            phase_next = 3'd0;
            if (port_reg) begin
              state_next = ST_COOLDOWN;
              cool_next  = '0;
              done_next  = 1'b1;
            end else begin
              port_next = 1'b1;
            end
          end else begin
            phase_next = phase_reg + 3'd1;
          end
        end else begin
          tick_next = tick_reg + TICK_W'(1);
        end
      end

      ST_COOLDOWN: begin
        cool_next = cool_reg + COOL_W'(1);
        if (cool_end) begin
          // A trigger landing on the final cooldown cycle is folded into pending.
          if (pending_reg || trig_reg) begin
            pending_next = 1'b0;
            state_next   = ST_PHASE;
            port_next    = 1'b0;
            phase_next   = 3'd0;
            tick_next    = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (trig_reg) begin
          pending_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign oBUSY      = (state_reg == ST_PHASE) || (state_reg == ST_COOLDOWN);
  assign oPOLL_DONE = done_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [5:0]  pad_lines;
    logic        active;
    logic        sample;
    logic        commit;
    logic        select;
    logic [11:0] shadow_reg;
    logic        has3_reg;
    logic        has6_reg;
    logic        ok6_reg;
    logic [11:0] decoded_reg, decoded_next;
    logic [1:0]  type_reg, type_next;

    assign pad_lines = (gi == 0) ? iPAD1 : iPAD2;
    assign active    = (state_reg == ST_PHASE) && (port_reg == 1'(gi));
    assign sample    = active && (tick_reg == TICK_W'(SETTLE_TICKS));
    assign commit    = active && last_phase;
    assign select    = ~(active & phase_reg[0]);

    // Shadow layout matches the decoded word: {Z,Y,X,M,S,C,B,A,U,D,L,R}.
    always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
        shadow_reg <= '0;
        has3_reg   <= 1'b0;
        has6_reg   <= 1'b0;
        ok6_reg    <= 1'b0;
      end else if (sample) begin
        case (phase_reg)
          3'd0: begin
            shadow_reg[6] <= ~pad_lines[5];
            shadow_reg[5] <= ~pad_lines[4];
            shadow_reg[3] <= ~pad_lines[3];
            shadow_reg[2] <= ~pad_lines[2];
            shadow_reg[1] <= ~pad_lines[1];
            shadow_reg[0] <= ~pad_lines[0];
          end
          3'd1: begin
            shadow_reg[7] <= ~pad_lines[5];
            shadow_reg[4] <= ~pad_lines[4];
            has3_reg      <= (pad_lines[1:0] == 2'b00);
          end
          3'd5: has6_reg <= (pad_lines[3:0] == 4'b0000);
          3'd6: shadow_reg[11:8] <= ~pad_lines[3:0];
          3'd7: ok6_reg <= (pad_lines[3:0] == 4'b1111);
          default: ;
        endcase
      end
    end

    always_comb begin
      decoded_next = {4'b0000, shadow_reg[7:0]};
      type_next    = 2'd1;
      if (!has3_reg) begin
        decoded_next = {6'b000000, shadow_reg[6:5], 1'b0, shadow_reg[3:0]};
        type_next    = 2'd0;
      end else if (has6_reg && ok6_reg) begin
        decoded_next = shadow_reg;
        type_next    = 2'd2;
      end else if (has6_reg) begin
        type_next = 2'd3;
      end
    end

    // Word and type change on the same edge so a reader never sees a mixed result.
    always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
        decoded_reg <= '0;
        type_reg    <= 2'd0;
      end else if (commit) begin
        decoded_reg <= decoded_next;
        type_reg    <= type_next;
      end
    end
  end

  assign oSELECT1      = g_port[0].select;
  assign oSELECT2      = g_port[1].select;
  assign oPAD1_DECODED = g_port[0].decoded_reg;
  assign oPAD2_DECODED = g_port[1].decoded_reg;
  assign oPAD1_TYPE    = g_port[0].type_reg;
  assign oPAD2_TYPE    = g_port[1].type_reg;

endmodule

// File: tb/tb_genesis_pad_poller.sv
// Randomized bench for genesis_pad_poller: TH-driven pad models on both ports, expectations from pad kind and held buttons.
module tb_genesis_pad_poller;

  localparam int P  = 20;
  localparam int ST = 5;
  localparam int CD = 100;
  localparam int LAT = 1 + 16 * P;
  localparam logic [11:0] MS_BUTTONS    = 12'h06F;  // C,B,U,D,L,R
  localparam logic [11:0] THREE_BUTTONS = 12'h0FF;  // S,C,B,A,U,D,L,R

  logic        iCLK = 1'b0;
  logic        iRESET;
  logic        iVBLANK;
  logic [5:0]  iPAD1, iPAD2;
  logic        oSELECT1, oSELECT2;
  logic [11:0] oPAD1_DECODED, oPAD2_DECODED;
  logic [1:0]  oPAD1_TYPE, oPAD2_TYPE;
  logic        oBUSY, oPOLL_DONE;

  int n_checks = 0;
  int n_pass   = 0;

  // Pad models: kind 0 Master System, 1 three-button, 2 six-button, 3 six-button with a bad phase-7 answer.
  int          kind [2] = '{0, 0};
  logic [11:0] btn  [2] = '{12'h000, 12'h000};
  logic [3:0]  bad7 [2] = '{4'h0, 4'h0};
  int          pcnt [2] = '{0, 0};
  int          quiet[2] = '{0, 0};
  logic        sel_prev [2] = '{1'b1, 1'b1};
  wire  [1:0]  sel_vec = {oSELECT2, oSELECT1};

  always #5 iCLK = ~iCLK;

  genesis_pad_poller #(
    .PHASE_TICKS(P), .SETTLE_TICKS(ST), .COOLDOWN_TICKS(CD), .AUTOPOLL_TICKS(1000)
  ) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iVBLANK(iVBLANK), .iPAD1(iPAD1), .iPAD2(iPAD2),
    .oSELECT1(oSELECT1), .oSELECT2(oSELECT2),
    .oPAD1_DECODED(oPAD1_DECODED), .oPAD2_DECODED(oPAD2_DECODED),
    .oPAD1_TYPE(oPAD1_TYPE), .oPAD2_TYPE(oPAD2_TYPE),
    .oBUSY(oBUSY), .oPOLL_DONE(oPOLL_DONE)
  );

  // Each pad counts TH transitions and forgets them after TH idles high for a while.
  always @(posedge iCLK) begin
    for (int i = 0; i < 2; i++) begin
      sel_prev[i] <= sel_vec[i];
      if (sel_vec[i] != sel_prev[i]) pcnt[i] <= pcnt[i] + 1;
      else if (sel_vec[i] && quiet[i] >= 2 * P) pcnt[i] <= 0;
      quiet[i] <= sel_vec[i] ? quiet[i] + 1 : 0;
    end
  end

  function automatic logic [5:0] pad_out(input int k, input logic [11:0] b, input logic [3:0] b7, input int ph);
    logic [5:0] norm;
    logic [1:0] hi;
    norm = ~{b[6], b[5], b[3], b[2], b[1], b[0]};
    hi   = ~{b[7], b[4]};
    if (k == 0) return norm;
    if (k >= 2 && ph == 6) return ~{b[6], b[5], b[11], b[10], b[9], b[8]};
    if (ph % 2 == 0) return norm;
    if (k >= 2 && ph == 5) return {hi, 4'b0000};
    if (k == 2 && ph == 7) return {hi, 4'b1111};
    if (k == 3 && ph == 7) return {hi, b7};
    return {hi, 4'b1100};
  endfunction

  always_comb iPAD1 = pad_out(kind[0], btn[0], bad7[0], pcnt[0]);
  always_comb iPAD2 = pad_out(kind[1], btn[1], bad7[1], pcnt[1]);

  function automatic logic [1:0] exp_type(input int k);
    case (k)
      0: return 2'd0;
      1: return 2'd1;
      2: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [11:0] exp_word(input int k, input logic [11:0] b);
    case (k)
      0: return b & MS_BUTTONS;
      2: return b;
      default: return b & THREE_BUTTONS;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic set_pad(input int i, input int k, input logic [11:0] b, input logic [3:0] b7);
    kind[i] = k;
    btn[i]  = b;
    bad7[i] = b7;
  endtask

  task automatic random_pad(input int i);
    int k;
    logic [11:0] b;
    k = $urandom_range(0, 3);
    b = 12'($urandom);
    if (k == 0 && b[1] && b[0]) b[0] = 1'b0;  // an MS pad with L+R held would look like a 3-button pad
    set_pad(i, k, b, 4'($urandom_range(0, 14)));
  endtask

  task automatic run_poll(input string tag);
    int cyc, done_cyc, fall1, low1, low2, low2_first, k;
    logic s1p;
    @(negedge iCLK); iVBLANK = 1'b1;
    @(posedge iCLK);
    cyc = 0; done_cyc = -1; fall1 = -1; low1 = 0; low2 = 0; low2_first = 0; s1p = 1'b1;
    while (done_cyc < 0 && cyc < 4000) begin
      @(posedge iCLK); cyc++;
      @(negedge iCLK);
      if (cyc == 3) iVBLANK = 1'b0;
      if (!oSELECT1) low1++;
      if (!oSELECT1 && s1p && fall1 < 0) fall1 = cyc;
      s1p = oSELECT1;
      if (!oSELECT2) begin
        low2++;
        if (cyc <= 1 + 8 * P) low2_first++;
      end
      if (oPOLL_DONE) done_cyc = cyc;
    end
    check({tag, ".latency"}, done_cyc, LAT);
    check({tag, ".sel1_fall"}, fall1, 1 + P);
    check({tag, ".sel1_low"}, low1, 4 * P);
    check({tag, ".sel2_low"}, low2, 4 * P);
    check({tag, ".sel2_first_half"}, low2_first, 0);
    check({tag, ".type1"}, oPAD1_TYPE, exp_type(kind[0]));
    check({tag, ".dec1"}, oPAD1_DECODED, exp_word(kind[0], btn[0]));
    check({tag, ".type2"}, oPAD2_TYPE, exp_type(kind[1]));
    check({tag, ".dec2"}, oPAD2_DECODED, exp_word(kind[1], btn[1]));
    $display("%s: kinds=%0d/%0d type1=%0d dec1=%03h type2=%0d dec2=%03h latency=%0d",
             tag, kind[0], kind[1], oPAD1_TYPE, oPAD1_DECODED, oPAD2_TYPE, oPAD2_DECODED, done_cyc);
    k = 0;
    while (oBUSY && k < CD + 20) begin
      @(posedge iCLK); k++;
      @(negedge iCLK);
      if (k == 1) check({tag, ".done_width"}, oPOLL_DONE, 1'b0);
    end
    check({tag, ".cooldown"}, k, CD);
  endtask

  task automatic pending_test(input string tag, input int t2, input int t3);
    int cyc, nd, d1, d2;
    @(negedge iCLK); iVBLANK = 1'b1;
    @(posedge iCLK);
    cyc = 0; nd = 0; d1 = -1; d2 = -1;
    while (cyc < 1 + 48 * P + 2 * CD + 40) begin
      @(posedge iCLK); cyc++;
      @(negedge iCLK);
      if (cyc == 3 || cyc == t2 + 2 || (t3 > 0 && cyc == t3 + 2)) iVBLANK = 1'b0;
      if (cyc == t2 || (t3 > 0 && cyc == t3)) iVBLANK = 1'b1;
      if (oPOLL_DONE) begin
        nd++;
        if (nd == 1) d1 = cyc;
        else if (nd == 2) d2 = cyc;
      end
    end
    check({tag, ".done_count"}, nd, 2);
    check({tag, ".first_done"}, d1, LAT);
    check({tag, ".second_done"}, d2, LAT + CD + 16 * P);
    check({tag, ".idle_after"}, oBUSY, 1'b0);
    $display("%s: polls=%0d first=%0d second=%0d", tag, nd, d1, d2);
  endtask

  task automatic reset_test();
    int cyc, nd;
    set_pad(0, 2, 12'($urandom) | 12'h001, 4'h0);
    random_pad(1);
    @(negedge iCLK); iVBLANK = 1'b1;
    @(posedge iCLK);
    cyc = 0;
    while (cyc < 1 + 11 * P + 3) begin
      @(posedge iCLK); cyc++;
      @(negedge iCLK);
      if (cyc == 3) iVBLANK = 1'b0;
    end
    check("rst.dec1_before", oPAD1_DECODED, exp_word(kind[0], btn[0]));
    check("rst.sel2_before", oSELECT2, 1'b0);
    iRESET = 1'b1;
    #1;
    check("rst.sel2", oSELECT2, 1'b1);
    check("rst.dec1", oPAD1_DECODED, 12'h000);
    check("rst.dec2", oPAD2_DECODED, 12'h000);
    check("rst.type1", oPAD1_TYPE, 2'd0);
    check("rst.busy", oBUSY, 1'b0);
    @(negedge iCLK); iRESET = 1'b0;
    nd = 0;
    for (int i = 0; i < LAT + CD; i++) begin
      @(negedge iCLK);
      if (oPOLL_DONE) nd++;
    end
    check("rst.no_done", nd, 0);
    $display("reset mid-poll: done pulses after reset=%0d", nd);
  endtask

  initial begin
    iRESET  = 1'b1;
    iVBLANK = 1'b1;
    repeat (3) @(negedge iCLK);
    check("reset.sel1", oSELECT1, 1'b1);
    check("reset.sel2", oSELECT2, 1'b1);
    check("reset.dec1", oPAD1_DECODED, 12'h000);
    check("reset.dec2", oPAD2_DECODED, 12'h000);
    check("reset.types", {oPAD1_TYPE, oPAD2_TYPE}, 4'h0);
    check("reset.busy", oBUSY, 1'b0);
    check("reset.done", oPOLL_DONE, 1'b0);
    iRESET = 1'b0;
    repeat (10) @(negedge iCLK);
    check("release.no_trigger", oBUSY, 1'b0);
    $display("reset: outputs idle, vblank held high across release");
    iVBLANK = 1'b0;
    repeat (2 * P + 5) @(negedge iCLK);

    set_pad(0, 1, 12'h018, 4'h0);
    set_pad(1, 0, 12'h000, 4'h0);
    run_poll("three_button");

    set_pad(0, 1, 12'h000, 4'h0);
    set_pad(1, 2, 12'h300, 4'h0);
    run_poll("six_button");

    set_pad(0, 3, 12'($urandom), 4'b0101);
    set_pad(1, 0, 12'h000, 4'h0);
    run_poll("ident_error");

    pending_test("pending", 100, 200);
    pending_test("late_trigger", 16 * P + CD - 1, -1);

    reset_test();
    random_pad(0);
    random_pad(1);
    run_poll("after_reset");

    for (int n = 0; n < 8; n++) begin
      random_pad(0);
      random_pad(1);
      run_poll($sformatf("random%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
